renode_ahb_arbiter: RTL

RENODE_AHB_ARBITER -- requirements
Module: renode_ahb_arbiter

---
 rtl/renode_ahb_pkg.sv | 58 +++++
 rtl/renode_rr_arbiter.sv | 27 ++
 rtl/renode_ahb_arbiter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/renode_ahb_pkg.sv
// Shared state, transfer and response types plus the size helpers used by the AHB arbiter.
package renode_ahb_pkg;

  typedef enum logic [1:0] {
    ArbIdle,
    ArbAddress,
    ArbData,
    ArbRespond
  } arb_state_e;

  typedef enum logic [1:0] {
    HtransIdle   = 2'b00,
    HtransBusy   = 2'b01,
    HtransNonSeq = 2'b10,
    HtransSeq    = 2'b11
  } htrans_e;

  typedef enum logic {
    HrespOkay  = 1'b0,
    HrespError = 1'b1
  } hresp_e;

  typedef logic [2:0] hsize_t;

  localparam hsize_t SizeByte  = 3'd0;
  localparam hsize_t SizeHalf  = 3'd1;
  localparam hsize_t SizeWord  = 3'd2;
  localparam hsize_t SizeDword = 3'd3;

  localparam logic [2:0] HburstSingle = 3'b000;

  typedef struct packed {
    logic   write;
    hsize_t size;
  } xfer_ctrl_t;

  function automatic logic sizeIsValid(input hsize_t size, input int unsigned busBytesLog2);
    return {29'd0, size} <= busBytesLog2;
  endfunction

  // Byte lane of the first active byte: address low bits limited to the bus and aligned to the size.
  function automatic logic [2:0] laneOffset(input hsize_t size, input logic [2:0] addrLow,
                                            input int unsigned busBytesLog2);
    logic [2:0] laneMask;
    logic [2:0] alignMask;
    laneMask  = 3'((32'd1 << busBytesLog2) - 32'd1);
    alignMask = ~3'((32'd1 << size) - 32'd1);
    return addrLow & laneMask & alignMask;
  endfunction

  function automatic logic [7:0] sizeToStrobe(input hsize_t size, input logic [2:0] addrLow,
                                              input int unsigned busBytesLog2);
    logic [15:0] byteMask;
    byteMask = 16'((32'd1 << (32'd1 << size)) - 32'd1);
    return 8'(byteMask << laneOffset(size, addrLow, busBytesLog2));
  endfunction

endpackage

// File: rtl/renode_rr_arbiter.sv
// Round-robin pick: first set request at or after the pointer, wrapping; grant is one-hot or zero.
module renode_rr_arbiter #(
  parameter int NumRequesters = 2,
  parameter int PtrWidth      = $clog2(NumRequesters)
) (
  input  logic [NumRequesters-1:0] i_req,
  input  logic [PtrWidth-1:0]      i_ptr,
  output logic [NumRequesters-1:0] o_grant
);

  logic [PtrWidth-1:0] w_idx;
  logic                w_found;

  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int off = 0; off < NumRequesters; off++) begin
      w_idx = PtrWidth'((int'(i_ptr) + off) % NumRequesters);
      if (!w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/renode_ahb_arbiter.sv
// AHB-Lite manager front end: round-robins single, non-overlapping transfers from several requesters.
module renode_ahb_arbiter
  import renode_ahb_pkg::*;
#(
  parameter int NumRequesters = 2,
  parameter int AddressWidth  = 32,
  parameter int DataWidth     = 32
) (
  input  logic                               hclk,
  input  logic                               hresetn,
  input  logic [NumRequesters-1:0]           req_valid,
  output logic [NumRequesters-1:0]           req_ready,
  input  logic [NumRequesters-1:0]           req_write,
  input  logic [NumRequesters*AddressWidth-1:0] req_addr,
  input  logic [NumRequesters*3-1:0]         req_size,
  input  logic [NumRequesters*DataWidth-1:0] req_wdata,
  output logic [NumRequesters-1:0]           rsp_valid,
  output logic [DataWidth-1:0]               rsp_rdata,
  output logic                               rsp_error,
  output logic [AddressWidth-1:0]            haddr,
  output logic [1:0]                         htrans,
  output logic                               hwrite,
  output logic [2:0]                         hsize,
  output logic [2:0]                         hburst,
  output logic [DataWidth/8-1:0]             hwstrb,
  output logic [DataWidth-1:0]               hwdata,
  input  logic [DataWidth-1:0]               hrdata,
  input  logic                               hready,
  input  logic                               hresp
);

  localparam int          PtrWidth     = $clog2(NumRequesters);
  localparam int          StrbWidth    = DataWidth / 8;
  localparam int unsigned BusBytesLog2 = $clog2(StrbWidth);

  arb_state_e                r_state, w_nextState;
  logic [PtrWidth-1:0]       r_rrPtr, r_grantIdx, w_grantIdx, w_nextPtr;
  logic [NumRequesters-1:0]  r_grant, w_grant;
  logic [AddressWidth-1:0]   r_addr;
  xfer_ctrl_t                r_ctrl;
  logic [DataWidth-1:0]      r_wdata, r_rdata, w_rdataShifted, w_rdataMasked;
  logic                      r_error;
  hsize_t                    w_reqSize;
  logic [2:0]                w_lane;
  logic [7:0]                w_strobe;

  renode_rr_arbiter #(.NumRequesters(NumRequesters)) u_rrArbiter (
    .i_req  (req_valid),
    .i_ptr  (r_rrPtr),
    .o_grant(w_grant)
  );

  always_comb begin
    w_grantIdx = '0;
    for (int i = 0; i < NumRequesters; i++)
      if (w_grant[i]) w_grantIdx = PtrWidth'(i);
  end

  assign w_reqSize = req_size[int'(w_grantIdx)*3 +: 3];
  assign w_nextPtr = (r_grantIdx == PtrWidth'(NumRequesters - 1)) ? '0 : r_grantIdx + PtrWidth'(1);

  // Read data is moved down from its byte lane, then trimmed to the transfer size.
  assign w_lane         = laneOffset(r_ctrl.size, r_addr[2:0], BusBytesLog2);
  assign w_strobe       = sizeToStrobe(r_ctrl.size, r_addr[2:0], BusBytesLog2);
  assign w_rdataShifted = hrdata >> {w_lane, 3'b000};

  always_comb begin
    w_rdataMasked = '0;
    for (int b = 0; b < StrbWidth; b++)
      if (b < (1 << r_ctrl.size)) w_rdataMasked[8*b +: 8] = w_rdataShifted[8*b +: 8];
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) r_state <= ArbIdle;
    else          r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    req_ready   = '0;
    rsp_valid   = '0;
    rsp_rdata   = '0;
    rsp_error   = 1'b0;
    htrans      = HtransIdle;
    hwstrb      = '0;
    hwdata      = '0;
    case (r_state)
      ArbIdle: begin
        if (hresetn) req_ready = w_grant;
        if (|req_valid)
          w_nextState = sizeIsValid(w_reqSize, BusBytesLog2) ? ArbAddress : ArbRespond;
      end
      ArbAddress: begin
        htrans = HtransNonSeq;
        if (hready) w_nextState = ArbData;
      end
      ArbData: begin
        hwdata = r_wdata;
        hwstrb = w_strobe[StrbWidth-1:0];
        if (hready) w_nextState = ArbRespond;
      end
      ArbRespond: begin
        rsp_valid   = r_grant;
        rsp_rdata   = r_rdata;
        rsp_error   = r_error;
        w_nextState = ArbIdle;
      end
      default: w_nextState = ArbIdle;
    endcase
  end

  assign haddr  = r_addr;
  assign hwrite = r_ctrl.write;
  assign hsize  = r_ctrl.size;
  assign hburst = HburstSingle;

  // An oversized request is pre-loaded as an error so it can go straight to Respond.
  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      r_rrPtr    <= '0;
      r_grant    <= '0;
      r_grantIdx <= '0;
      r_addr     <= '0;
      r_ctrl     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_error    <= 1'b0;
    end else begin
      case (r_state)
        ArbIdle: begin
          if (|req_valid) begin
            r_grant    <= w_grant;
            r_grantIdx <= w_grantIdx;
            r_addr     <= req_addr[int'(w_grantIdx)*AddressWidth +: AddressWidth];
            r_ctrl     <= '{write: req_write[w_grantIdx], size: w_reqSize};
            r_wdata    <= req_wdata[int'(w_grantIdx)*DataWidth +: DataWidth];
            r_error    <= !sizeIsValid(w_reqSize, BusBytesLog2);
            r_rdata    <= '0;
          end
        end
        ArbData: begin
          if (hready) begin
            r_error <= (hresp == HrespError);
            r_rdata <= (r_ctrl.write || hresp == HrespError) ? '0 : w_rdataMasked;
          end
        end
        ArbRespond: r_rrPtr <= w_nextPtr;
        default: ;
      endcase
    end
  end

endmodule
